uart_cmd_responder: RTL and testbench

UART_CMD_RESPONDER -- requirements
Module: uart_cmd_responder

---
 rtl/uart_cmd_responder_if.sv | 20 ++
 rtl/uart_cmd_responder.sv | 145 ++++++++++++++
 tb/tb_uart_cmd_responder.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_responder_if.sv
// Byte-level link between the command responder and its UART receiver/transmitter.
// The responder takes the slave view; the UART side (or a bench) takes the master view.
interface uart_cmd_responder_if;
    logic       Rx_valid;
    logic [7:0] rx_data;
    logic       o_Tx_DV;
    logic [7:0] o_Tx_Byte;
    logic       i_Tx_Active;
    logic       i_Tx_Done;

    modport slave (
        input  Rx_valid, rx_data, i_Tx_Active, i_Tx_Done,
        output o_Tx_DV, o_Tx_Byte
    );

    modport master (
        output Rx_valid, rx_data, i_Tx_Active, i_Tx_Done,
        input  o_Tx_DV, o_Tx_Byte
    );
endinterface

// File: rtl/uart_cmd_responder.sv
// Byte-command responder: 'W' addr data writes a 16x8 register file and ACKs,
// 'R' addr replies with the register; bad opcodes/addresses get a NAK.
module uart_cmd_responder #(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                     MAX10_CLK1_50,
    input  logic                     rst,
    uart_cmd_responder_if.slave      bus,
    output logic [7:0]               o_reg0,
    output logic                     o_busy,
    output logic                     o_overrun,
    output logic                     o_timeout
);

    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] RSP_ACK  = 8'h06;
    localparam logic [7:0] RSP_NAK  = 8'h15;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        SEND,
        WAIT_DONE
    } state_e;

    state_e           state_q;
    logic             is_write_q;
    logic [3:0]       addr_q;
    logic [7:0]       tx_byte_q;
    logic             tx_dv_q;
    logic             overrun_q;
    logic             timeout_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       regs_q [16];

    // NOTE: every register here is state, so it is only ever assigned with <=;
    // a blocking = would let later reads in this block see the new value early.
    always_ff @(posedge MAX10_CLK1_50) begin
        if (!rst) begin
            state_q    <= IDLE;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            tx_byte_q  <= '0;
            tx_dv_q    <= 1'b0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
            cnt_q      <= '0;
            // NOTE: the register file must come up as all zeros, so it is a reset
            // flop array rather than a RAM macro (which could not be cleared in one edge).
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            tx_dv_q   <= 1'b0;
            timeout_q <= 1'b0;
            if (bus.Rx_valid) begin
                cnt_q <= '0;
            end

            case (state_q)
                IDLE: begin
                    if (bus.Rx_valid) begin
                        if (bus.rx_data == OP_READ || bus.rx_data == OP_WRITE) begin
                            is_write_q <= (bus.rx_data == OP_WRITE);
                            state_q    <= GET_ADDR;
                        end else begin
                            tx_byte_q <= RSP_NAK;
                            state_q   <= SEND;
                        end
                    end
                end

                GET_ADDR: begin
                    if (bus.Rx_valid) begin
                        if (bus.rx_data[7:4] != 4'h0) begin
                            tx_byte_q <= RSP_NAK;
                            state_q   <= SEND;
                        end else if (is_write_q) begin
                            addr_q  <= bus.rx_data[3:0];
                            state_q <= GET_DATA;
                        end else begin
                            tx_byte_q <= regs_q[bus.rx_data[3:0]];
                            state_q   <= SEND;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        timeout_q <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                GET_DATA: begin
                    if (bus.Rx_valid) begin
                        regs_q[addr_q] <= bus.rx_data;
                        tx_byte_q      <= RSP_ACK;
                        state_q        <= SEND;
                    end else if (cnt_q == CNT_LAST) begin
                        // Partial write abandoned: nothing reaches the register file.
                        timeout_q <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                SEND: begin
                    if (bus.Rx_valid) begin
                        overrun_q <= 1'b1;
                    end
                    if (!bus.i_Tx_Active) begin
                        tx_dv_q <= 1'b1;
                        state_q <= WAIT_DONE;
                    end
                end

                WAIT_DONE: begin
                    if (bus.Rx_valid) begin
                        overrun_q <= 1'b1;
                    end
                    if (bus.i_Tx_Done) begin
                        state_q <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_Tx_DV   = tx_dv_q;
    assign bus.o_Tx_Byte = tx_byte_q;
    assign o_reg0        = regs_q[0];
    assign o_busy        = (state_q != IDLE);
    assign o_overrun     = overrun_q;
    assign o_timeout     = timeout_q;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder: commands, errors, transmit handshake,
// inter-byte timeout, overrun and reset behaviour, each with hand-computed results.
module tb_uart_cmd_responder;

    logic       clk;
    logic       rst;
    logic [7:0] o_reg0;
    logic       o_busy;
    logic       o_overrun;
    logic       o_timeout;

    int total = 0;
    int bad   = 0;

    uart_cmd_responder_if bus ();

    uart_cmd_responder #(.TIMEOUT_CYCLES(20)) dut (
        .MAX10_CLK1_50 (clk),
        .rst           (rst),
        .bus           (bus),
        .o_reg0        (o_reg0),
        .o_busy        (o_busy),
        .o_overrun     (o_overrun),
        .o_timeout     (o_timeout)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Called at a negedge; the byte is sampled on the next rising edge.
    task automatic send_byte(input logic [7:0] b);
        bus.Rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
        bus.Rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    // Waits (bounded) for the transmit strobe, records latency and byte, checks the
    // strobe is single with the byte held, then answers with i_Tx_Done. lat=-1 on expiry.
    task automatic collect_tx(output int lat, output logic [7:0] b, output logic single);
        lat = 0;
        while (bus.o_Tx_DV !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        if (bus.o_Tx_DV !== 1'b1) begin
            lat    = -1;
            b      = 8'hxx;
            single = 1'b0;
            return;
        end
        b = bus.o_Tx_Byte;
        @(negedge clk);
        single = (bus.o_Tx_DV === 1'b0) && (bus.o_Tx_Byte === b) && (o_busy === 1'b1);
        bus.i_Tx_Done = 1'b1;
        @(negedge clk);
        bus.i_Tx_Done = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (o_busy !== 1'b0 || bus.o_Tx_DV !== 1'b0 || bus.o_Tx_Byte !== 8'h00 ||
            o_overrun !== 1'b0 || o_timeout !== 1'b0 || o_reg0 !== 8'h00) begin
            bad++;
            $display("FAIL reset_state: busy=%b dv=%b byte=%02h ovr=%b tmo=%b reg0=%02h, want 0 0 00 0 0 00",
                     o_busy, bus.o_Tx_DV, bus.o_Tx_Byte, o_overrun, o_timeout, o_reg0);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_read;
        int lat; logic [7:0] b; logic single;
        send_byte(8'h57); send_byte(8'h03); send_byte(8'hA5);
        total++;
        if (bus.o_Tx_DV !== 1'b0 || o_busy !== 1'b1) begin
            bad++;
            $display("FAIL latency_n1: dv=%b busy=%b, want dv=0 busy=1", bus.o_Tx_DV, o_busy);
        end
        collect_tx(lat, b, single);
        total++;
        if (lat != 1 || b !== 8'h06 || single !== 1'b1) begin
            bad++;
            $display("FAIL write_ack: lat=%0d byte=%02h single=%b, want lat=1 byte=06 single=1", lat, b, single);
        end
        send_byte(8'h52); send_byte(8'h03);
        collect_tx(lat, b, single);
        total++;
        if (lat != 1 || b !== 8'hA5 || single !== 1'b1) begin
            bad++;
            $display("FAIL read_back: lat=%0d byte=%02h single=%b, want lat=1 byte=A5 single=1", lat, b, single);
        end
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h3C);
        collect_tx(lat, b, single);
        total++;
        if (b !== 8'h06 || o_reg0 !== 8'h3C) begin
            bad++;
            $display("FAIL reg0_write: byte=%02h reg0=%02h, want byte=06 reg0=3C", b, o_reg0);
        end
    endtask

    task automatic test_errors;
        int lat; logic [7:0] b; logic single;
        send_byte(8'h41);
        collect_tx(lat, b, single);
        total++;
        if (lat != 1 || b !== 8'h15 || o_reg0 !== 8'h3C || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL bad_opcode: lat=%0d byte=%02h reg0=%02h busy=%b, want lat=1 byte=15 reg0=3C busy=0",
                     lat, b, o_reg0, o_busy);
        end
        send_byte(8'h52); send_byte(8'h10);
        collect_tx(lat, b, single);
        total++;
        if (lat != 1 || b !== 8'h15) begin
            bad++;
            $display("FAIL read_addr_10: lat=%0d byte=%02h, want lat=1 byte=15", lat, b);
        end
        send_byte(8'h57); send_byte(8'hFF);
        collect_tx(lat, b, single);
        total++;
        if (lat != 1 || b !== 8'h15 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL write_addr_ff: lat=%0d byte=%02h busy=%b, want lat=1 byte=15 busy=0", lat, b, o_busy);
        end
        send_byte(8'h57); send_byte(8'h0F); send_byte(8'h81);
        collect_tx(lat, b, single);
        send_byte(8'h52); send_byte(8'h0F);
        collect_tx(lat, b, single);
        total++;
        if (lat != 1 || b !== 8'h81) begin
            bad++;
            $display("FAIL addr_0f_edge: lat=%0d byte=%02h, want lat=1 byte=81", lat, b);
        end
    endtask

    task automatic test_back_to_back;
        int lat; logic [7:0] b; logic single;
        send_byte(8'h57); send_byte(8'h03); send_byte(8'h5A);
        collect_tx(lat, b, single);
        send_byte(8'h52); send_byte(8'h03);
        collect_tx(lat, b, single);
        total++;
        if (lat != 1 || b !== 8'h5A || single !== 1'b1) begin
            bad++;
            $display("FAIL newest_value: lat=%0d byte=%02h single=%b, want lat=1 byte=5A single=1", lat, b, single);
        end
    endtask

    task automatic test_handshake;
        int dv_seen;
        bus.i_Tx_Active = 1'b1;
        send_byte(8'h52); send_byte(8'h03);
        dv_seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.o_Tx_DV === 1'b1) dv_seen++;
        end
        total++;
        if (dv_seen != 0 || o_busy !== 1'b1) begin
            bad++;
            $display("FAIL held_while_active: dv_cycles=%0d busy=%b, want 0 and busy=1", dv_seen, o_busy);
        end
        bus.i_Tx_Active = 1'b0;
        @(negedge clk);
        total++;
        if (bus.o_Tx_DV !== 1'b1 || bus.o_Tx_Byte !== 8'h5A) begin
            bad++;
            $display("FAIL dv_after_release: dv=%b byte=%02h, want dv=1 byte=5A", bus.o_Tx_DV, bus.o_Tx_Byte);
        end
        @(negedge clk);
        total++;
        if (bus.o_Tx_DV !== 1'b0 || bus.o_Tx_Byte !== 8'h5A) begin
            bad++;
            $display("FAIL dv_single: dv=%b byte=%02h, want dv=0 byte=5A", bus.o_Tx_DV, bus.o_Tx_Byte);
        end
        bus.i_Tx_Done = 1'b1;
        @(negedge clk);
        bus.i_Tx_Done = 1'b0;
    endtask

    task automatic test_timeout;
        int lat; logic [7:0] b; logic single;
        int waited;
        logic tmo_seen;
        send_byte(8'h57); send_byte(8'h05);
        waited = 0;
        while (o_timeout !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (waited != 20) begin
            bad++;
            $display("FAIL timeout_cycle: pulse after %0d cycles, want 20", waited);
        end
        @(negedge clk);
        total++;
        if (o_timeout !== 1'b0 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL timeout_pulse: tmo=%b busy=%b one cycle later, want 0 0", o_timeout, o_busy);
        end
        send_byte(8'h52); send_byte(8'h05);
        collect_tx(lat, b, single);
        total++;
        if (lat != 1 || b !== 8'h00) begin
            bad++;
            $display("FAIL timeout_no_write: lat=%0d byte=%02h, want lat=1 byte=00", lat, b);
        end
        send_byte(8'h57); send_byte(8'h06);
        tmo_seen = 1'b0;
        repeat (19) begin
            @(negedge clk);
            if (o_timeout === 1'b1) tmo_seen = 1'b1;
        end
        send_byte(8'hC3);
        total++;
        if (tmo_seen !== 1'b0 || o_timeout !== 1'b0 || o_busy !== 1'b1) begin
            bad++;
            $display("FAIL byte_on_expiry: tmo_seen=%b tmo=%b busy=%b, want 0 0 1", tmo_seen, o_timeout, o_busy);
        end
        collect_tx(lat, b, single);
        send_byte(8'h52); send_byte(8'h06);
        collect_tx(lat, b, single);
        total++;
        if (lat != 1 || b !== 8'hC3) begin
            bad++;
            $display("FAIL expiry_write_kept: lat=%0d byte=%02h, want lat=1 byte=C3", lat, b);
        end
    endtask

    task automatic test_overrun;
        int lat; logic [7:0] b; logic single;
        total++;
        if (o_overrun !== 1'b0) begin
            bad++;
            $display("FAIL overrun_clear: ovr=%b, want 0", o_overrun);
        end
        send_byte(8'h57); send_byte(8'h09); send_byte(8'h77);
        @(negedge clk);
        send_byte(8'h11);
        total++;
        if (o_overrun !== 1'b1 || bus.o_Tx_Byte !== 8'h06 || o_busy !== 1'b1 || bus.o_Tx_DV !== 1'b0) begin
            bad++;
            $display("FAIL overrun_set: ovr=%b byte=%02h busy=%b dv=%b, want 1 06 1 0",
                     o_overrun, bus.o_Tx_Byte, o_busy, bus.o_Tx_DV);
        end
        bus.i_Tx_Done = 1'b1;
        @(negedge clk);
        bus.i_Tx_Done = 1'b0;
        send_byte(8'h52); send_byte(8'h09);
        collect_tx(lat, b, single);
        total++;
        if (lat != 1 || b !== 8'h77 || o_overrun !== 1'b1) begin
            bad++;
            $display("FAIL after_overrun: lat=%0d byte=%02h ovr=%b, want lat=1 byte=77 ovr=1", lat, b, o_overrun);
        end
    endtask

    task automatic test_reset_midcommand;
        int lat; logic [7:0] b; logic single;
        send_byte(8'h57); send_byte(8'h07);
        rst = 1'b0;
        bus.Rx_valid = 1'b1;
        bus.rx_data  = 8'h99;
        @(negedge clk);
        bus.Rx_valid = 1'b0;
        total++;
        if (o_busy !== 1'b0 || bus.o_Tx_DV !== 1'b0 || bus.o_Tx_Byte !== 8'h00 ||
            o_overrun !== 1'b0 || o_timeout !== 1'b0 || o_reg0 !== 8'h00) begin
            bad++;
            $display("FAIL reset_get_data: busy=%b dv=%b byte=%02h ovr=%b tmo=%b reg0=%02h, want 0 0 00 0 0 00",
                     o_busy, bus.o_Tx_DV, bus.o_Tx_Byte, o_overrun, o_timeout, o_reg0);
        end
        rst = 1'b1;
        @(negedge clk);
        send_byte(8'h52); send_byte(8'h07);
        collect_tx(lat, b, single);
        total++;
        if (lat != 1 || b !== 8'h00) begin
            bad++;
            $display("FAIL no_pending_write: lat=%0d byte=%02h, want lat=1 byte=00", lat, b);
        end
        send_byte(8'h52); send_byte(8'h03);
        collect_tx(lat, b, single);
        total++;
        if (lat != 1 || b !== 8'h00) begin
            bad++;
            $display("FAIL regs_cleared: lat=%0d byte=%02h, want lat=1 byte=00", lat, b);
        end
        send_byte(8'h57); send_byte(8'h08); send_byte(8'h44);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (o_busy !== 1'b0 || bus.o_Tx_DV !== 1'b0 || bus.o_Tx_Byte !== 8'h00 || o_timeout !== 1'b0) begin
            bad++;
            $display("FAIL reset_wait_done: busy=%b dv=%b byte=%02h tmo=%b, want 0 0 00 0",
                     o_busy, bus.o_Tx_DV, bus.o_Tx_Byte, o_timeout);
        end
        rst = 1'b1;
        bus.i_Tx_Done = 1'b1;
        @(negedge clk);
        bus.i_Tx_Done = 1'b0;
        @(negedge clk);
        total++;
        if (o_busy !== 1'b0 || bus.o_Tx_DV !== 1'b0) begin
            bad++;
            $display("FAIL done_in_idle: busy=%b dv=%b, want 0 0", o_busy, bus.o_Tx_DV);
        end
        send_byte(8'h52); send_byte(8'h08);
        collect_tx(lat, b, single);
        total++;
        if (lat != 1 || b !== 8'h00) begin
            bad++;
            $display("FAIL reg8_cleared: lat=%0d byte=%02h, want lat=1 byte=00", lat, b);
        end
    endtask

    initial begin
        rst             = 1'b0;
        bus.Rx_valid    = 1'b0;
        bus.rx_data     = 8'h00;
        bus.i_Tx_Active = 1'b0;
        bus.i_Tx_Done   = 1'b0;
        @(negedge clk);
        test_reset;
        test_write_read;
        test_errors;
        test_back_to_back;
        test_handshake;
        test_timeout;
        test_overrun;
        test_reset_midcommand;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
